// File: rtl/time_split_ctrl.sv
// rtl/time_split_ctrl.sv - seconds count to day/hour/min/sec via one shared restoring divider
// Optional one-deep pending request slot: define TIME_SPLIT_QUEUE_EN.
module time_split_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    time_in,
   output logic                busy,
   output logic                done,
   output logic [5:0]          sec,
   output logic [5:0]          min,
   output logic [4:0]          hour,
   output logic [WIDTH-17:0]   day
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ITER,
      ST_FINISH
   } state_t;

   localparam int         DW        = WIDTH - 16;
   localparam logic [6:0] LAST_STEP = 7'(WIDTH - 1);

   state_t           state_q,    state_d;
   logic [1:0]       stage_q,    stage_d;
   logic [6:0]       cnt_q,      cnt_d;
   logic [6:0]       rem_q,      rem_d;
   logic [WIDTH-1:0] quo_q,      quo_d;
   logic [5:0]       sec_s_q,    sec_s_d;
   logic [5:0]       min_s_q,    min_s_d;
   logic [4:0]       hour_s_q,   hour_s_d;
   logic [DW-1:0]    day_s_q,    day_s_d;
   logic [5:0]       sec_q,      sec_d;
   logic [5:0]       min_q,      min_d;
   logic [4:0]       hour_q,     hour_d;
   logic [DW-1:0]    day_q,      day_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
`ifdef TIME_SPLIT_QUEUE_EN
   logic             pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0] pend_time_q,  pend_time_d;
`endif

   // Divider datapath: one restoring shift-subtract step on the (rem,quo) pair.
   // The dividend lives in quo and shifts out MSB first while quotient bits
   // shift in at the LSB, so after WIDTH steps quo holds the full quotient.
   logic [6:0]       divisor;
   logic [7:0]       trial;
   logic             take;
   logic [6:0]       diff;
   logic [6:0]       step_rem;
   logic [WIDTH-1:0] step_quo;

   // Shared shift-subtract step; divisor chosen by stage (60, 60, 24)
   always_comb begin
      divisor  = (stage_q == 2'd2) ? 7'd24 : 7'd60;
      trial    = {rem_q, quo_q[WIDTH-1]};
      take     = (trial >= {1'b0, divisor});
      // When take is set the trial is below twice the divisor, so 7 bits suffice.
      diff     = trial[6:0] - divisor;
      step_rem = take ? diff : trial[6:0];
      step_quo = {quo_q[WIDTH-2:0], take};
   end

   logic             launch;
   logic [WIDTH-1:0] launch_val;

   // Next-state logic for the sequencer, staging registers and result outputs
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      sec_s_d    = sec_s_q;
      min_s_d    = min_s_q;
      hour_s_d   = hour_s_q;
      day_s_d    = day_s_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      day_d      = day_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      launch     = 1'b0;
      launch_val = time_in;
`ifdef TIME_SPLIT_QUEUE_EN
      pend_valid_d = pend_valid_q;
      pend_time_d  = pend_time_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef TIME_SPLIT_QUEUE_EN
            if (start) begin
               launch       = 1'b1;
               launch_val   = time_in;
               pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
               launch       = 1'b1;
               launch_val   = pend_time_q;
               pend_valid_d = 1'b0;
            end
`else
            if (start) begin
               launch     = 1'b1;
               launch_val = time_in;
            end
`endif
         end

         ST_ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LAST_STEP) begin
               case (stage_q)
                  2'd0: begin
                     sec_s_d = step_rem[5:0];
                     state_d = ST_SETUP;
                  end
                  2'd1: begin
                     min_s_d = step_rem[5:0];
                     state_d = ST_SETUP;
                  end
                  default: begin
                     hour_s_d = step_rem[4:0];
                     day_s_d  = step_quo[DW-1:0];
                     state_d  = ST_FINISH;
                  end
               endcase
            end
         end

         ST_SETUP: begin
            // Previous quotient stays in quo as the next dividend.
            rem_d   = 7'd0;
            cnt_d   = 7'd0;
            stage_d = stage_q + 2'd1;
            state_d = ST_ITER;
         end

         ST_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sec_d   = sec_s_q;
            min_d   = min_s_q;
            hour_d  = hour_s_q;
            day_d   = day_s_q;
            state_d = ST_IDLE;
`ifdef TIME_SPLIT_QUEUE_EN
            if (pend_valid_q) begin
               launch       = 1'b1;
               launch_val   = pend_time_q;
               pend_valid_d = 1'b0;
            end
`endif
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // A launch doubles as the stage-0 setup: load dividend, clear remainder.
      if (launch) begin
         quo_d   = launch_val;
         rem_d   = 7'd0;
         cnt_d   = 7'd0;
         stage_d = 2'd0;
         busy_d  = 1'b1;
         state_d = ST_ITER;
      end

`ifdef TIME_SPLIT_QUEUE_EN
      // Requests arriving mid-conversion (FINISH included) park in the slot;
      // the latest one wins. Evaluated after launch so a FINISH-edge request
      // is kept while the older pending one starts.
      if (start && busy_q) begin
         pend_time_d  = time_in;
         pend_valid_d = 1'b1;
      end
`endif
   end

   // State and datapath registers; reset discards any in-flight conversion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         stage_q  <= 2'd0;
         cnt_q    <= 7'd0;
         rem_q    <= 7'd0;
         quo_q    <= '0;
         sec_s_q  <= 6'd0;
         min_s_q  <= 6'd0;
         hour_s_q <= 5'd0;
         day_s_q  <= '0;
         sec_q    <= 6'd0;
         min_q    <= 6'd0;
         hour_q   <= 5'd0;
         day_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef TIME_SPLIT_QUEUE_EN
         pend_valid_q <= 1'b0;
         pend_time_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         sec_s_q  <= sec_s_d;
         min_s_q  <= min_s_d;
         hour_s_q <= hour_s_d;
         day_s_q  <= day_s_d;
         sec_q    <= sec_d;
         min_q    <= min_d;
         hour_q   <= hour_d;
         day_q    <= day_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef TIME_SPLIT_QUEUE_EN
         pend_valid_q <= pend_valid_d;
         pend_time_q  <= pend_time_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sec  = sec_q;
   assign min  = min_q;
   assign hour = hour_q;
   assign day  = day_q;

endmodule

// File: tb/tb_time_split_ctrl.sv
// tb/tb_time_split_ctrl.sv - self-checking bench for time_split_ctrl (default build)
module tb_time_split_ctrl;

   localparam int W   = 32;
   localparam int LAT = 3 * W + 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  time_in;
   logic          busy;
   logic          done;
   logic [5:0]    sec;
   logic [5:0]    min;
   logic [4:0]    hour;
   logic [W-17:0] day;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   time_split_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .time_in (time_in),
      .busy    (busy),
      .done    (done),
      .sec     (sec),
      .min     (min),
      .hour    (hour),
      .day     (day)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: accept when idle, result appears LAT edges later.
   bit              m_busy, m_done;
   int              m_left;
   longint unsigned m_sec, m_min, m_hour, m_day;
   longint unsigned p_sec, p_min, p_hour, p_day;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_left = 0;
         m_sec = 0; m_min = 0; m_hour = 0; m_day = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1; m_busy = 0;
               m_sec = p_sec; m_min = p_min; m_hour = p_hour; m_day = p_day;
            end
         end else if (start) begin
            longint unsigned t;
            t      = 64'(time_in);
            m_busy = 1;
            m_left = LAT;
            p_sec  = t % 60;
            p_min  = (t / 60) % 60;
            p_hour = (t / 3600) % 24;
            p_day  = t / 86400;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("sec",  64'(sec),  m_sec);
         check("min",  64'(min),  m_min);
         check("hour", 64'(hour), m_hour);
         check("day",  64'(day),  m_day);
      end
   end

   task automatic expect_fields(input string name, input longint unsigned d, input longint unsigned h,
                                input longint unsigned m, input longint unsigned s);
      check({name, "_day"},  64'(day),  d);
      check({name, "_hour"}, 64'(hour), h);
      check({name, "_min"},  64'(min),  m);
      check({name, "_sec"},  64'(sec),  s);
      check({name, "_model_day"}, m_day, d);
      check({name, "_model_sec"}, m_sec, s);
   endtask

   // Count edges after the current one until done is seen (bounded).
   task automatic wait_done(input string name, input int exp_lat);
      int lat;
      lat = -1;
      for (int n = 1; n <= LAT + 20; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check(name, 64'(lat), 64'(exp_lat));
      check({name, "_busy_low"}, 64'(busy), 64'd0);
   endtask

   task automatic run_conv(input string name, input logic [W-1:0] t);
      @(posedge clk); #1;
      start   = 1'b1;
      time_in = t;
      @(posedge clk); #1;          // edge 0
      start = 1'b0;
      wait_done(name, LAT);
   endtask

   initial begin
      int stray;
      rst_n   = 1'b0;
      start   = 1'b0;
      time_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      expect_fields("rst", 0, 0, 0, 0);

      run_conv("lat_a", 32'd65478898);
      expect_fields("vec_a", 757, 20, 34, 58);

      run_conv("lat_zero", 32'd0);
      expect_fields("vec_zero", 0, 0, 0, 0);

      run_conv("lat_max_day", 32'd86399);
      expect_fields("vec_86399", 0, 23, 59, 59);

      run_conv("lat_ones", 32'hFFFFFFFF);
      expect_fields("vec_ones", 49710, 6, 28, 15);

      // start held high: second accept at edge 100, inputs in between ignored
      @(posedge clk); #1;
      start   = 1'b1;
      time_in = 32'd100000;
      @(posedge clk); #1;          // edge 0
      time_in = 32'd3661;
      wait_done("b2b_first", LAT);
      expect_fields("b2b_a", 1, 3, 46, 40);
      wait_done("b2b_second", LAT + 1);
      expect_fields("b2b_b", 0, 1, 1, 1);
      start = 1'b0;
      repeat (2) @(posedge clk);

      // asynchronous reset mid-conversion
      @(posedge clk); #1;
      start   = 1'b1;
      time_in = 32'd123456;
      @(posedge clk); #1;          // edge 0
      start = 1'b0;
      repeat (50) @(posedge clk);  // edge 50
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      expect_fields("arst", 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stray = 0;
      for (int n = 0; n < LAT + 20; n++) begin
         @(posedge clk); #1;
         if (done) stray++;
      end
      check("arst_no_done", 64'(stray), 64'd0);
      run_conv("lat_after_rst", 32'd86399);
      expect_fields("after_rst", 0, 23, 59, 59);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
